pass_lock_ctrl: RTL and testbench

Sequencing controller for the password-comparison datapath of the access-lock subsystem. It accepts one code word per handshake and compares all PASS_W bits against the stored password. It tracks consecutive failures and enforces a timed lockout after MAX_TRIES failures. On a match it holds the unlock output for a bounded window.

---
 rtl/pass_lock_ctrl.sv | 118 +++++++++++
 tb/tb_pass_lock_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pass_lock_ctrl.sv
// Password-comparison sequencer: accepts one code per handshake, checks it against PASSWORD,
// counts consecutive failures and times the unlock window and the lockout penalty.
module pass_lock_ctrl #(
  parameter int unsigned         PASS_W         = 4,
  parameter logic [PASS_W-1:0]   PASSWORD       = 4'b1010,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter int unsigned         UNLOCK_CYCLES  = 8,
  parameter int unsigned         LOCKOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PASS_W-1:0] code_in,
  input  logic              code_valid,
  input  logic              relock,
  output logic              ready,
  output logic              unlocked,
  output logic              locked_out,
  output logic              grant,
  output logic              deny,
  output logic [3:0]        fail_cnt
);

  localparam int unsigned MaxCycles =
      (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TimerW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [1:0] {StIdle, StCheck, StOpen, StLockout} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [PASS_W-1:0]   code_q, code_d;
  logic [3:0]          fail_d, fail_inc;
  logic                ready_d, unlocked_d, locked_out_d, grant_d, deny_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    code_d   = code_q;
    fail_d   = fail_cnt;
    grant_d  = 1'b0;
    deny_d   = 1'b0;
    fail_inc = fail_cnt + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (code_valid) begin
          code_d  = code_in;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (code_q == PASSWORD) begin
          state_d = StOpen;
          grant_d = 1'b1;
          fail_d  = 4'd0;
          timer_d = TimerW'(UNLOCK_CYCLES - 1);
        end else begin
          deny_d = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == 4'(MAX_TRIES)) begin
            state_d = StLockout;
            timer_d = TimerW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOpen: begin
        // Relock and expiry share one exit path, so coincidence needs no special case.
        if (relock || (timer_q == '0)) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          fail_d  = 4'd0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Level outputs follow the next state so they flip on the same edge as the state.
    ready_d      = (state_d == StIdle);
    unlocked_d   = (state_d == StOpen);
    locked_out_d = (state_d == StLockout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      code_q     <= '0;
      fail_cnt   <= 4'd0;
      ready      <= 1'b1;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      grant      <= 1'b0;
      deny       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
      fail_cnt   <= fail_d;
      ready      <= ready_d;
      unlocked   <= unlocked_d;
      locked_out <= locked_out_d;
      grant      <= grant_d;
      deny       <= deny_d;
    end
  end

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Bench for pass_lock_ctrl: directed scenarios plus random traffic, all outputs compared
// every cycle against a countdown-based reference model.
module tb_pass_lock_ctrl;

  localparam logic [3:0]  Pw        = 4'b1010;
  localparam int unsigned MaxTries  = 3;
  localparam int unsigned UnlockN   = 8;
  localparam int unsigned LockoutN  = 16;
  localparam logic [8:0]  ResetVec  = 9'b1_0_0_0_0_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_in;
  logic       code_valid;
  logic       relock;
  logic       ready, unlocked, locked_out, grant, deny;
  logic [3:0] fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining-cycle counters instead of an explicit state machine.
  int         m_open_left;
  int         m_lock_left;
  int         m_fails;
  bit         m_pending;
  bit         m_grant;
  bit         m_deny;
  logic [3:0] m_code;

  pass_lock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .relock     (relock),
    .ready      (ready),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .grant      (grant),
    .deny       (deny),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {ready, unlocked, locked_out, grant, deny, fail_cnt};
  endfunction

  function automatic logic [8:0] mdl_vec();
    logic r;
    r = !m_pending && (m_open_left == 0) && (m_lock_left == 0);
    return {r, m_open_left > 0, m_lock_left > 0, m_grant, m_deny, 4'(m_fails)};
  endfunction

  task automatic model_reset();
    m_open_left = 0;
    m_lock_left = 0;
    m_fails     = 0;
    m_pending   = 0;
    m_grant     = 0;
    m_deny      = 0;
    m_code      = '0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c, input bit r);
    m_grant = 0;
    m_deny  = 0;
    if (m_pending) begin
      m_pending = 0;
      if (m_code == Pw) begin
        m_grant     = 1;
        m_fails     = 0;
        m_open_left = UnlockN;
      end else begin
        m_deny  = 1;
        m_fails = m_fails + 1;
        if (m_fails == MaxTries) m_lock_left = LockoutN;
      end
    end else if (m_open_left > 0) begin
      m_open_left = r ? 0 : m_open_left - 1;
    end else if (m_lock_left > 0) begin
      m_lock_left = m_lock_left - 1;
      if (m_lock_left == 0) m_fails = 0;
    end else if (v) begin
      m_pending = 1;
      m_code    = c;
    end
  endtask

  task automatic cyc(input bit v, input logic [3:0] c, input bit r);
    code_valid = v;
    code_in    = c;
    relock     = r;
    @(posedge clk);
    model_step(v, c, r);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    code_valid = 1'b0;
    code_in = '0;
    relock = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec() !== ResetVec) begin
      n_fail++;
      $display("FAIL reset_async got=%b want=%b", dut_vec(), ResetVec);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'h0, 1'b0);
      n_tests++;
      if (dut_vec() !== ResetVec) begin
        n_fail++;
        $display("FAIL reset_idle c%0d got=%b want=%b", i, dut_vec(), ResetVec);
      end
    end
  endtask

  task automatic test_correct();
    int n_unl = 0;
    int n_gnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(i == 0, Pw, 1'b0);
      n_unl += int'(unlocked);
      n_gnt += int'(grant);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL correct c%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
      if (i == 1) begin
        n_tests++;
        if (grant !== 1'b1 || ready !== 1'b0) begin
          n_fail++;
          $display("FAIL correct_latency grant=%b ready=%b want grant=1 ready=0", grant, ready);
        end
      end
    end
    n_tests++;
    if (n_unl != UnlockN || n_gnt != 1 || dut_vec() !== ResetVec) begin
      n_fail++;
      $display("FAIL correct_window unl=%0d gnt=%0d vec=%b want 8 1 %b",
               n_unl, n_gnt, dut_vec(), ResetVec);
    end
  endtask

  task automatic test_wrong();
    cyc(1'b1, 4'b1011, 1'b0);
    cyc(1'b0, 4'b1011, 1'b0);
    n_tests++;
    if (dut_vec() !== 9'b1_0_0_0_1_0001) begin
      n_fail++;
      $display("FAIL wrong_deny got=%b want=%b", dut_vec(), 9'b1_0_0_0_1_0001);
    end
    cyc(1'b1, Pw, 1'b0);
    cyc(1'b0, Pw, 1'b0);
    n_tests++;
    if (dut_vec() !== 9'b0_1_0_1_0_0000) begin
      n_fail++;
      $display("FAIL wrong_then_grant got=%b want=%b", dut_vec(), 9'b0_1_0_1_0_0000);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 4'h0, 1'b0);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL wrong c%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic enter_lockout(input string tag);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1, 4'(k - 1), 1'b0);
      cyc(1'b0, 4'h0, 1'b0);
      n_tests++;
      if (fail_cnt !== 4'(k) || deny !== 1'b1 || dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL %s_fail%0d got=%b want=%b fail_cnt=%0d want %0d",
                 tag, k, dut_vec(), mdl_vec(), fail_cnt, k);
      end
    end
  endtask

  task automatic test_lockout();
    int n_lock;
    int n_gnt = 0;
    enter_lockout("lockout");
    n_lock = int'(locked_out);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, Pw, 1'b1);
      n_lock += int'(locked_out);
      n_gnt  += int'(grant);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL lockout c%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    n_tests++;
    if (n_lock != LockoutN || n_gnt != 0 || dut_vec() !== ResetVec) begin
      n_fail++;
      $display("FAIL lockout_window lock=%0d gnt=%0d vec=%b want 16 0 %b",
               n_lock, n_gnt, dut_vec(), ResetVec);
    end
    cyc(1'b1, Pw, 1'b0);
    cyc(1'b0, Pw, 1'b0);
    n_tests++;
    if (grant !== 1'b1 || unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL lockout_recover grant=%b unlocked=%b want 1 1", grant, unlocked);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_relock();
    int rel_at[2] = '{3, 8};
    int want[2]   = '{3, 8};
    for (int t = 0; t < 2; t++) begin
      int n_unl = 0;
      cyc(1'b1, Pw, 1'b0);
      for (int j = 0; j < 11; j++) begin
        cyc(1'b0, 4'h0, j == rel_at[t]);
        n_unl += int'(unlocked);
        n_tests++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++;
          $display("FAIL relock%0d c%0d got=%b want=%b", t, j, dut_vec(), mdl_vec());
        end
      end
      n_tests++;
      if (n_unl != want[t] || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL relock%0d_window unl=%0d ready=%b want %0d 1", t, n_unl, ready, want[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_gnt = 0;
    int last_gnt = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, Pw, 1'b0);
      if (grant) begin
        n_gnt++;
        last_gnt = i;
      end
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL held_valid c%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    n_tests++;
    if (n_gnt != 2 || last_gnt != 12) begin
      n_fail++;
      $display("FAIL held_valid_grants n=%0d last=%0d want 2 12", n_gnt, last_gnt);
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        enter_lockout("areset");
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'h0, 1'b0);
      end else begin
        cyc(1'b1, Pw, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (dut_vec() !== ResetVec) begin
        n_fail++;
        $display("FAIL areset%0d got=%b want=%b", t, dut_vec(), ResetVec);
      end
      #2 rst = 1'b0;
      model_reset();
      cyc(1'b1, Pw, 1'b0);
      cyc(1'b0, 4'h0, 1'b0);
      n_tests++;
      if (dut_vec() !== 9'b0_1_0_1_0_0000) begin
        n_fail++;
        $display("FAIL areset%0d_recover got=%b want=%b", t, dut_vec(), 9'b0_1_0_1_0_0000);
      end
      for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit         v;
      bit         r;
      logic [3:0] c;
      v = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 1) == 0) ? Pw : 4'($urandom_range(0, 15));
      cyc(v, c, r);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL random c%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_lockout();
    test_relock();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
